// File: rtl/dmc_sample_reader.sv
// dmc_sample_reader
//   Delta-modulation sample channel in the style of the 2A03 DMC. Reads
//   sample bytes one at a time from the latch RAM byte port. Each byte is
//   shifted out LSB first, one bit per rate tick, into a 7-bit delta DAC
//   counter: a 1 bit adds 2 and a 0 bit subtracts 2, and the counter
//   saturates instead of wrapping.
//
//   Ports
//     clk, rstn          clock, asynchronous active-low reset
//     start / stop       playback control pulses
//     loop_en, irq_en    loop at end of sample / allow end-of-sample irq
//     irq_clear          pulse, clears irq
//     sample_addr/len    first byte address and byte count (0 = empty)
//     period             rate timer reload value (tick every period+1 clk)
//     dac_load/value     direct load of the DAC counter
//     mem_addr, mem_read_n, mem_data, mem_ready
//                        RAM byte read master (11 idle, 00 8-bit read)
//     dac_out            delta counter output
//     irq                end-of-sample interrupt
//     active             bytes still to be fetched
//
//   Build option
//     DMC_RATE_TABLE_EN  when defined, period[3:0] selects an NTSC rate
//                        table entry instead of being used as a raw count.
module dmc_sample_reader #(
    parameter int RAM_BYTES   = 32,
    parameter int ADDR_BITS   = 5,
    parameter int PERIOD_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic                   irq_en,
    input  logic                   irq_clear,
    input  logic [ADDR_BITS-1:0]   sample_addr,
    input  logic [ADDR_BITS:0]     sample_len,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   dac_load,
    input  logic [6:0]             dac_value,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [1:0]             mem_read_n,
    input  logic [7:0]             mem_data,
    input  logic                   mem_ready,
    output logic [6:0]             dac_out,
    output logic                   irq,
    output logic                   active
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_BITS:0]     LEN_ONE    = 1;
    localparam logic [ADDR_BITS-1:0]   ADDR_ONE   = 1;
    localparam logic [ADDR_BITS-1:0]   LAST_ADDR  = ADDR_BITS'(RAM_BYTES - 1);
    localparam logic [PERIOD_BITS-1:0] PERIOD_ONE = 1;

    // Saturating delta step: +2 / -2, holding at the ends instead of wrapping.
    function automatic logic [6:0] dac_step(input logic [6:0] v, input logic up);
        if (up) begin
            return (v <= 7'd125) ? v + 7'd2 : v;
        end
        return (v >= 7'd2) ? v - 7'd2 : v;
    endfunction

    function automatic logic [PERIOD_BITS-1:0] reload_value(input logic [PERIOD_BITS-1:0] p);
`ifdef DMC_RATE_TABLE_EN
        logic [8:0] entry;
        case (p[3:0])
            4'd0:    entry = 9'd428;
            4'd1:    entry = 9'd380;
            4'd2:    entry = 9'd340;
            4'd3:    entry = 9'd320;
            4'd4:    entry = 9'd286;
            4'd5:    entry = 9'd254;
            4'd6:    entry = 9'd226;
            4'd7:    entry = 9'd214;
            4'd8:    entry = 9'd190;
            4'd9:    entry = 9'd160;
            4'd10:   entry = 9'd142;
            4'd11:   entry = 9'd128;
            4'd12:   entry = 9'd106;
            4'd13:   entry = 9'd84;
            4'd14:   entry = 9'd72;
            default: entry = 9'd54;
        endcase
        return PERIOD_BITS'(entry - 9'd1);
`else
        return p;
`endif
    endfunction

    logic [1:0]             state_q, state_d;
    logic [ADDR_BITS:0]     bytes_rem_q, bytes_rem_d;
    logic [ADDR_BITS-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]             read_n_q, read_n_d;
    logic [7:0]             buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   silence_q, silence_d;
    logic [3:0]             bits_left_q, bits_left_d;
    logic [7:0]             shift_q, shift_d;
    logic [PERIOD_BITS-1:0] timer_q, timer_d;
    logic [6:0]             dac_q, dac_d;
    logic                   irq_q, irq_d;
    logic                   tick;
    logic                   irq_set;

    always_comb begin
        state_d     = state_q;
        bytes_rem_d = bytes_rem_q;
        cur_addr_d  = cur_addr_q;
        mem_addr_d  = mem_addr_q;
        read_n_d    = read_n_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        silence_d   = silence_q;
        bits_left_d = bits_left_q;
        shift_d     = shift_q;
        dac_d       = dac_q;
        irq_d       = irq_q;
        irq_set     = 1'b0;

        // The period input is only sampled at reload, so a change waits
        // for the current interval to finish.
        tick    = (timer_q == '0);
        timer_d = tick ? reload_value(period) : timer_q - PERIOD_ONE;

        if (tick) begin
            if (!silence_q) begin
                dac_d = dac_step(dac_q, shift_q[0]);
            end
            shift_d = shift_q >> 1;
            if (bits_left_q == 4'd1) begin
                bits_left_d = 4'd8;
                if (buf_full_q) begin
                    shift_d    = buf_q;
                    buf_full_d = 1'b0;
                    silence_d  = 1'b0;
                end else begin
                    // Underflow: play a silent byte period.
                    silence_d = 1'b1;
                end
            end else begin
                bits_left_d = bits_left_q - 4'd1;
            end
        end

        // A direct load overrides the tick's DAC update; the shifter above
        // still advances.
        if (dac_load) begin
            dac_d = dac_value;
        end

        // The reader only runs while the buffer is empty. The shifter only
        // empties a full buffer, so the two never touch buf_full in the
        // same cycle.
        case (state_q)
            S_IDLE: begin
                if (!buf_full_q && bytes_rem_q != '0) begin
                    state_d    = S_REQ;
                    mem_addr_d = cur_addr_q;
                    read_n_d   = 2'b00;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    buf_d      = mem_data;
                    buf_full_d = 1'b1;
                    read_n_d   = 2'b11;
                    state_d    = S_DONE;
                    cur_addr_d = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_ONE;
                    if (bytes_rem_q == LEN_ONE) begin
                        if (loop_en) begin
                            cur_addr_d  = sample_addr;
                            bytes_rem_d = sample_len;
                        end else begin
                            bytes_rem_d = '0;
                            irq_set     = irq_en;
                        end
                    end else if (bytes_rem_q != '0) begin
                        bytes_rem_d = bytes_rem_q - LEN_ONE;
                    end
                end
            end
            S_DONE: begin
                // One idle cycle between reads lets the RAM's beat counter reset.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start && bytes_rem_q == '0) begin
            cur_addr_d  = sample_addr;
            bytes_rem_d = sample_len;
        end
        if (stop) begin
            bytes_rem_d = '0;
        end

        if (start || irq_clear) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end
        if (!irq_en) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            bytes_rem_q <= '0;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            read_n_q    <= 2'b11;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            silence_q   <= 1'b1;
            bits_left_q <= 4'd8;
            shift_q     <= '0;
            timer_q     <= '0;
            dac_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bytes_rem_q <= bytes_rem_d;
            cur_addr_q  <= cur_addr_d;
            mem_addr_q  <= mem_addr_d;
            read_n_q    <= read_n_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            silence_q   <= silence_d;
            bits_left_q <= bits_left_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            dac_q       <= dac_d;
            irq_q       <= irq_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_read_n = read_n_q;
    assign dac_out    = dac_q;
    // Dropping irq_en masks the output at once; the flop clears on the next edge.
    assign irq        = irq_q & irq_en;
    assign active     = (bytes_rem_q != '0);

endmodule

// File: tb/tb_dmc_sample_reader.sv
// Testbench for dmc_sample_reader: a RAM responder, a DAC change monitor
// and a sample-level reference model (address sequence, clamped delta walk).
module tb_dmc_sample_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, irq_en = 1'b0, irq_clear = 1'b0;
    logic [4:0]  sample_addr = '0;
    logic [5:0]  sample_len = '0;
    logic [11:0] period = '0;
    logic        dac_load = 1'b0;
    logic [6:0]  dac_value = '0;
    logic [4:0]  mem_addr;
    logic [1:0]  mem_read_n;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [6:0]  dac_out;
    logic        irq, active;

    dmc_sample_reader dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .loop_en(loop_en),
        .irq_en(irq_en), .irq_clear(irq_clear), .sample_addr(sample_addr),
        .sample_len(sample_len), .period(period), .dac_load(dac_load),
        .dac_value(dac_value), .mem_addr(mem_addr), .mem_read_n(mem_read_n),
        .mem_data(mem_data), .mem_ready(mem_ready), .dac_out(dac_out),
        .irq(irq), .active(active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [7:0] ram [32];
    int lat = 2;
    int cyc = 0;
    int req_cnt = 0;
    int idle_cnt = 10;
    int prev_dac = -1;
    int rd_addr_q[$];
    int dac_val_q[$];
    int dac_cyc_q[$];
    int exp_dac_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM byte port: data_ready after 'lat' cycles of a held request.
    initial begin
        mem_ready = 1'b0;
        mem_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_read_n == 2'b00) begin
                if (req_cnt == 0) check("rd_gap", int'(idle_cnt >= 1), 1);
                req_cnt++;
                idle_cnt = 0;
                if (req_cnt >= lat && !mem_ready) begin
                    mem_ready = 1'b1;
                    mem_data  = ram[mem_addr];
                    rd_addr_q.push_back(int'(mem_addr));
                end
            end else begin
                mem_ready = 1'b0;
                req_cnt   = 0;
                idle_cnt++;
            end
        end
    end

    // Records every change of dac_out with the cycle it became visible.
    initial forever begin
        @(negedge clk);
        if (int'(dac_out) != prev_dac) begin
            dac_val_q.push_back(int'(dac_out));
            dac_cyc_q.push_back(cyc);
            prev_dac = int'(dac_out);
        end
    end

    function automatic int interval(input int p);
`ifdef DMC_RATE_TABLE_EN
        int t[16] = '{428, 380, 340, 320, 286, 254, 226, 214, 190, 160, 142, 128, 106, 84, 72, 54};
        return t[p % 16];
`else
        return p + 1;
`endif
    endfunction

    // Walks the sample bits LSB first with a saturating +/-2 counter and
    // keeps only the value changes; returns the final counter value.
    function automatic int model_dac(input int addr, input int len, input int dac0);
        int v, nv, b;
        v = dac0;
        exp_dac_q.delete();
        for (int i = 0; i < len; i++) begin
            b = int'(ram[(addr + i) % 32]);
            for (int k = 0; k < 8; k++) begin
                if ((b >> k) & 1) nv = (v + 2 > 127) ? v : v + 2;
                else              nv = (v - 2 < 0) ? v : v - 2;
                if (nv != v) exp_dac_q.push_back(nv);
                v = nv;
            end
        end
        return v;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_and_start(input int dac0);
        @(negedge clk);
        dac_load = 1'b1;
        dac_value = 7'(dac0);
        @(negedge clk);
        dac_load = 1'b0;
        @(negedge clk);
        rd_addr_q.delete();
        dac_val_q.delete();
        dac_cyc_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_play(input int addr, input int len, input int per, input int dac0,
                            input int ien, input string tag);
        int iv, fin, n;
        loop_en = 1'b0;
        irq_en = ien[0];
        sample_addr = 5'(addr);
        sample_len = 6'(len);
        period = 12'(per);
        do_reset();
        load_and_start(dac0);
        @(negedge clk);
        check($sformatf("%s_first_rd", tag), int'(mem_read_n), (len != 0) ? 0 : 3);
        iv = interval(per);
        repeat ((len + 3) * 8 * iv + len * (lat + 6) + 40) @(negedge clk);
        check($sformatf("%s_nreads", tag), rd_addr_q.size(), len);
        n = (rd_addr_q.size() < len) ? rd_addr_q.size() : len;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_addr%0d", tag, i), rd_addr_q[i], (addr + i) % 32);
        fin = model_dac(addr, len, dac0);
        check($sformatf("%s_ndac", tag), dac_val_q.size(), exp_dac_q.size());
        n = (dac_val_q.size() < exp_dac_q.size()) ? dac_val_q.size() : exp_dac_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_dac%0d", tag, i), dac_val_q[i], exp_dac_q[i]);
        for (int i = 1; i < dac_cyc_q.size(); i++)
            check($sformatf("%s_space%0d", tag, i), (dac_cyc_q[i] - dac_cyc_q[i-1]) % iv, 0);
        check($sformatf("%s_final_dac", tag), int'(dac_out), fin);
        check($sformatf("%s_irq", tag), int'(irq), (len != 0) ? ien : 0);
        check($sformatf("%s_active", tag), int'(active), 0);
        check($sformatf("%s_idle_rd", tag), int'(mem_read_n), 3);
    endtask

    initial begin
        int sz, found, a, l, p, d, e;
        for (int i = 0; i < 32; i++) ram[i] = 8'(i * 37 + 11);

        // Reset state.
        #1 rstn = 1'b0;
        #1;
        check("rst_dac", int'(dac_out), 0);
        check("rst_irq", int'(irq), 0);
        check("rst_rdn", int'(mem_read_n), 3);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_active", int'(active), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Single all-ones byte rising from 64.
        ram[4] = 8'hFF;
        run_play(4, 1, 3, 64, 0, "ones");

        // Address wrap 31 -> 0 -> 1, irq at end, then irq_clear.
        ram[31] = 8'hAA; ram[0] = 8'h55; ram[1] = 8'h0F;
        run_play(31, 3, 2, 60, 1, "wrap");
        @(negedge clk) irq_clear = 1'b1;
        @(negedge clk) irq_clear = 1'b0;
        check("irq_clear", int'(irq), 0);

        // Saturation at both ends, and an empty sample.
        ram[5] = 8'hFF;
        run_play(5, 1, 1, 127, 0, "clamp_hi");
        ram[6] = 8'h00;
        run_play(6, 1, 1, 1, 0, "clamp_lo");
        run_play(7, 0, 1, 30, 1, "empty");

        // irq set wins over a same-cycle irq_clear; irq_en=0 masks at once.
        loop_en = 1'b0; irq_en = 1'b1; sample_addr = 5'd3; sample_len = 6'd1; period = 12'd2;
        do_reset();
        load_and_start(10);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_ready) found = 1;
        end
        check("irq_ready_seen", found, 1);
        irq_clear = 1'b1;
        @(posedge clk);
        #1 check("irq_set_over_clear", int'(irq), 1);
        @(negedge clk) irq_clear = 1'b0;
        check("irq_held", int'(irq), 1);
        irq_en = 1'b0;
        #1 check("irq_en_mask", int'(irq), 0);
        @(posedge clk);
        #1 irq_en = 1'b1;
        #1 check("irq_en_cleared", int'(irq), 0);

        // Looping sample 8,9,8,9..., then stop during a request.
        loop_en = 1'b1; irq_en = 1'b1; sample_addr = 5'd8; sample_len = 6'd2; period = 12'd0;
        lat = 2;
        do_reset();
        load_and_start(64);
        for (int i = 0; i < 400 && rd_addr_q.size() < 6; i++) @(negedge clk);
        check("loop_nreads", int'(rd_addr_q.size() >= 6), 1);
        for (int i = 0; i < 6 && i < rd_addr_q.size(); i++)
            check($sformatf("loop_addr%0d", i), rd_addr_q[i], 8 + (i % 2));
        check("loop_irq", int'(irq), 0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_read_n == 2'b00 && req_cnt == 1) found = 1;
        end
        check("stop_req_seen", found, 1);
        sz = rd_addr_q.size();
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        repeat (100) @(negedge clk);
        check("stop_inflight_done", rd_addr_q.size(), sz + 1);
        check("stop_rdn", int'(mem_read_n), 3);
        check("stop_active", int'(active), 0);
        check("stop_irq", int'(irq), 0);
        loop_en = 1'b0;

        // dac_load on a tick wins; the shifter still advances.
        ram[10] = 8'h03;
        irq_en = 1'b0; sample_addr = 5'd10; sample_len = 6'd1; period = 12'd3;
        do_reset();
        load_and_start(20);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dac_out != 7'd20) found = 1;
        end
        check("tick_first", int'(dac_out), 22);
        repeat (3) @(negedge clk);
        dac_load = 1'b1;
        dac_value = 7'd50;
        @(posedge clk);
        #1 check("tick_load", int'(dac_out), 50);
        @(negedge clk) dac_load = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("tick_after_load", int'(dac_out), 48);

        // Asynchronous reset in the middle of a request.
        lat = 50;
        irq_en = 1'b1; sample_addr = 5'd0; sample_len = 6'd3; period = 12'd1;
        do_reset();
        load_and_start(40);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_read_n == 2'b00) found = 1;
        end
        check("arst_req_seen", found, 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_rdn", int'(mem_read_n), 3);
        check("arst_dac", int'(dac_out), 0);
        check("arst_irq", int'(irq), 0);
        check("arst_active", int'(active), 0);
        @(negedge clk) rstn = 1'b1;
        lat = 2;
        repeat (60) @(negedge clk);
        check("arst_no_read", rd_addr_q.size(), 0);
        check("arst_idle", int'(mem_read_n), 3);

        // Randomized samples.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
            lat = int'($urandom_range(1, 3));
            a = int'($urandom_range(0, 31));
            l = int'($urandom_range(1, 6));
            p = int'($urandom_range(0, 6));
            d = int'($urandom_range(0, 127));
            e = int'($urandom_range(0, 1));
            run_play(a, l, p, d, e, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
